// File: rtl/jtopll_wrq_if.sv
// jtopll_wrq_if -- bus bundle for the OPLL CPU write queue.
//
// CPU side : cpu_wr, cpu_addr (0 = register select, 1 = data), cpu_din[7:0]
// Status   : full, empty, busy, overflow
// mmr side : mmr_write (one-clk strobe), mmr_addr, mmr_din[7:0]
//
// Modports:
//   master - host side: drives the cpu_* request and observes status/mmr outputs
//   slave  - the queue itself: accepts cpu_* and drives status/mmr outputs
interface jtopll_wrq_if;
  logic       cpu_wr;
  logic       cpu_addr;
  logic [7:0] cpu_din;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       mmr_write;
  logic       mmr_addr;
  logic [7:0] mmr_din;

  modport master (
    output cpu_wr, cpu_addr, cpu_din,
    input  full, empty, busy, overflow, mmr_write, mmr_addr, mmr_din
  );

  modport slave (
    input  cpu_wr, cpu_addr, cpu_din,
    output full, empty, busy, overflow, mmr_write, mmr_addr, mmr_din
  );
endinterface

// File: rtl/jtopll_wrq.sv
// jtopll_wrq -- CPU-side write queue and pacer for the OPLL register interface.
//
// CPU writes are buffered in a 2^DW entry FIFO of {addr, din} and replayed to
// the mmr as single-clock write strobes. After each issued write the block
// waits ADDR_WAIT (register select) or DATA_WAIT (data) cen ticks before the
// next one, so a host can write back-to-back without polling the chip.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset; flushes the queue
//   cen  - clock enable shared with the mmr; only the wait countdown uses it
//   bus  - jtopll_wrq_if.slave: cpu_wr/cpu_addr/cpu_din in,
//          full/empty/busy/overflow status, mmr_write/mmr_addr/mmr_din out
//
// Parameters:
//   DW        - log2 of FIFO depth
//   ADDR_WAIT - cen ticks after a register-select write (0..255)
//   DATA_WAIT - cen ticks after a data write (0..255)
//
// Optional feature macro: JTOPLL_WRQ_SKIPADDR_EN
//   When defined, a queued register-select write that repeats the last issued
//   selection is dropped instead of issued (no strobe, no wait).
module jtopll_wrq #(
  parameter int DW        = 3,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jtopll_wrq_if.slave    bus
);

  localparam int DEPTH = 1 << DW;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  function automatic logic [7:0] wait_len(input logic is_data);
    return is_data ? 8'(DATA_WAIT) : 8'(ADDR_WAIT);
  endfunction

  logic [8:0]    mem [DEPTH];
  logic [DW-1:0] wr_ptr;
  logic [DW-1:0] rd_ptr;
  logic [DW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          push;
  logic          pop;
  logic          skip;
  logic [8:0]    head;

  state_t        state;
  logic [7:0]    wcnt;
  logic          mmr_write;
  logic          mmr_addr;
  logic [7:0]    mmr_din;

  // count never exceeds DEPTH, so its top bit alone flags a full queue
  assign full  = count[DW];
  assign empty = (count == '0);
  assign push  = bus.cpu_wr && !full;
  assign pop   = (state == IDLE) && !empty;
  assign head  = mem[rd_ptr];

`ifdef JTOPLL_WRQ_SKIPADDR_EN
  logic [7:0] last_sel;
  logic       last_sel_vld;
  assign skip = !head[8] && last_sel_vld && (head[7:0] == last_sel);
`else
  assign skip = 1'b0;
`endif

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cpu_addr, bus.cpu_din};
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // a write arriving while full is lost even if a pop frees a slot this cycle
      if (bus.cpu_wr && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue / pacing state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      mmr_write <= 1'b0;
      mmr_addr  <= 1'b0;
      mmr_din   <= '0;
`ifdef JTOPLL_WRQ_SKIPADDR_EN
      last_sel     <= '0;
      last_sel_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mmr_write <= 1'b0;
          // a skipped entry is still popped; IDLE looks at the FIFO again next cycle
          if (pop && !skip) begin
            mmr_addr  <= head[8];
            mmr_din   <= head[7:0];
            mmr_write <= 1'b1;
            state     <= ISSUE;
`ifdef JTOPLL_WRQ_SKIPADDR_EN
            if (!head[8]) begin
              last_sel     <= head[7:0];
              last_sel_vld <= 1'b1;
            end
`endif
          end
        end
        ISSUE: begin
          mmr_write <= 1'b0;
          wcnt      <= wait_len(mmr_addr);
          state     <= WAIT;
        end
        WAIT: begin
          // zero is checked before cen so a wait of 0 still costs one clk
          if (wcnt == '0)  state <= IDLE;
          else if (cen)    wcnt  <= wcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.busy      = !empty || (state != IDLE);
  assign bus.overflow  = overflow;
  assign bus.mmr_write = mmr_write;
  assign bus.mmr_addr  = mmr_addr;
  assign bus.mmr_din   = mmr_din;

endmodule

// File: tb/tb_jtopll_wrq.sv
// tb_jtopll_wrq -- directed testbench for jtopll_wrq (DW=3, ADDR_WAIT=12, DATA_WAIT=84).
// Cycle k is the clk period following the k-th rising edge; inputs are set
// and outputs read 1 time unit after the edge. Strobes are logged at the
// falling edge with their cycle number.
// Honours JTOPLL_WRQ_SKIPADDR_EN in the skip scenario.
module tb_jtopll_wrq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen;
  logic cen_div = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int         s_cyc [$];
  logic       s_addr[$];
  logic [7:0] s_din [$];

  jtopll_wrq_if bus();

  jtopll_wrq #(.DW(3), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb cen = cen_div ? (cyc[1:0] == 2'b00) : 1'b1;

  always @(negedge clk) begin
    if (bus.mmr_write === 1'b1) begin
      s_cyc.push_back(cyc);
      s_addr.push_back(bus.mmr_addr);
      s_din.push_back(bus.mmr_din);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic a, input logic [7:0] d);
    bus.cpu_wr   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    step();
    bus.cpu_wr   = 1'b0;
  endtask

  task automatic clear_log();
    s_cyc.delete();
    s_addr.delete();
    s_din.delete();
  endtask

  task automatic wait_idle(input int max, output int low);
    low = -1;
    for (int k = 0; k < max; k++) begin
      if (bus.busy === 1'b0) begin
        low = cyc;
        break;
      end
      step();
    end
    checks++;
    if (low < 0) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d clks, required 0", bus.busy, max);
    end
  endtask

  task automatic test_reset();
    bus.cpu_wr = 1'b0; bus.cpu_addr = 1'b0; bus.cpu_din = 8'h00;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({bus.full, bus.empty, bus.busy, bus.overflow} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_status: full/empty/busy/ovf=%b required 0100",
               {bus.full, bus.empty, bus.busy, bus.overflow});
    end
    checks++;
    if ({bus.mmr_write, bus.mmr_addr, bus.mmr_din} !== 10'h000) begin
      errors++;
      $display("FAIL reset_mmr: write/addr/din=%b/%b/%h required 0/0/00",
               bus.mmr_write, bus.mmr_addr, bus.mmr_din);
    end
    clear_log();
    repeat (100) step();
    checks++;
    if (s_cyc.size() != 0) begin
      errors++;
      $display("FAIL idle_strobes: got %0d strobes required 0", s_cyc.size());
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_status: empty=%b busy=%b required 1/0", bus.empty, bus.busy);
    end
  endtask

  task automatic test_single();
    int base;
    clear_log();
    base = cyc;
    push(1'b0, 8'h10);
    for (int i = 1; i <= 17; i++) begin
      checks++;
      if (bus.mmr_write !== (i == 2) || bus.busy !== (i <= 15)) begin
        errors++;
        $display("FAIL single_c%0d: write=%b busy=%b required %b/%b",
                 i, bus.mmr_write, bus.busy, (i == 2), (i <= 15));
      end
      if (i == 2) begin
        checks++;
        if (bus.mmr_addr !== 1'b0 || bus.mmr_din !== 8'h10) begin
          errors++;
          $display("FAIL single_value: addr=%b din=%h required 0/10", bus.mmr_addr, bus.mmr_din);
        end
      end
      step();
    end
    checks++;
    if (s_cyc.size() != 1 || bus.mmr_din !== 8'h10) begin
      errors++;
      $display("FAIL single_hold: strobes=%0d din=%h required 1/10", s_cyc.size(), bus.mmr_din);
    end
    if (base < 0) $display("unreachable");
  endtask

  task automatic test_back_to_back();
    int base, low;
    clear_log();
    base = cyc;
    push(1'b0, 8'h10);
    push(1'b1, 8'h55);
    wait_idle(300, low);
    checks++;
    if (s_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes required 2", s_cyc.size());
    end else begin
      checks++;
      if (s_cyc[0] - base != 2 || s_cyc[1] - s_cyc[0] != 15) begin
        errors++;
        $display("FAIL b2b_timing: first at +%0d gap %0d required +2/15",
                 s_cyc[0] - base, s_cyc[1] - s_cyc[0]);
      end
      checks++;
      if (s_addr[1] !== 1'b1 || s_din[1] !== 8'h55) begin
        errors++;
        $display("FAIL b2b_value: addr=%b din=%h required 1/55", s_addr[1], s_din[1]);
      end
      checks++;
      if (low - s_cyc[1] != 86) begin
        errors++;
        $display("FAIL b2b_busy: busy low %0d clks after strobe required 86", low - s_cyc[1]);
      end
    end
  endtask

  task automatic test_cen_pacing();
    int low, gap;
    clear_log();
    cen_div = 1'b1;
    push(1'b1, 8'h33);
    push(1'b1, 8'h44);
    wait_idle(1000, low);
    cen_div = 1'b0;
    checks++;
    if (s_cyc.size() != 2) begin
      errors++;
      $display("FAIL cen_count: got %0d strobes required 2", s_cyc.size());
    end else begin
      gap = s_cyc[1] - s_cyc[0];
      checks++;
      if (gap < 336 || gap > 339) begin
        errors++;
        $display("FAIL cen_gap: got %0d clks required 336..339", gap);
      end
      checks++;
      if (s_din[0] !== 8'h33 || s_din[1] !== 8'h44) begin
        errors++;
        $display("FAIL cen_value: din %h,%h required 33,44", s_din[0], s_din[1]);
      end
    end
  endtask

  task automatic test_overflow();
    int low;
    clear_log();
    for (int i = 0; i < 10; i++) begin
      bus.cpu_wr   = 1'b1;
      bus.cpu_addr = 1'b1;
      bus.cpu_din  = 8'hA0 + 8'(i);
      if (i == 8) begin
        checks++;
        if (bus.full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_notfull: full=%b required 0 before 9th push", bus.full);
        end
      end
      if (i == 9) begin
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: full=%b overflow=%b required 1/0", bus.full, bus.overflow);
        end
      end
      step();
    end
    bus.cpu_wr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: overflow=%b full=%b required 1/1", bus.overflow, bus.full);
    end
    wait_idle(1200, low);
    checks++;
    if (s_cyc.size() != 9) begin
      errors++;
      $display("FAIL ovf_count: got %0d strobes required 9", s_cyc.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (s_addr[i] !== 1'b1 || s_din[i] !== 8'hA0 + 8'(i) ||
            (i > 0 && s_cyc[i] - s_cyc[i-1] != 87)) begin
          errors++;
          $display("FAIL ovf_entry%0d: addr=%b din=%h gap=%0d required 1/%h/87",
                   i, s_addr[i], s_din[i], (i > 0) ? s_cyc[i] - s_cyc[i-1] : 87, 8'hA0 + 8'(i));
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b required 1", bus.overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) push(1'b1, 8'h60 + 8'(i));
    checks++;
    if (bus.busy !== 1'b1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: busy=%b empty=%b required 1/0", bus.busy, bus.empty);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.empty, bus.busy, bus.mmr_write, bus.overflow, bus.full} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset: empty/busy/write/ovf/full=%b required 10000",
               {bus.empty, bus.busy, bus.mmr_write, bus.overflow, bus.full});
    end
    checks++;
    if (bus.mmr_din !== 8'h00 || bus.mmr_addr !== 1'b0) begin
      errors++;
      $display("FAIL mid_mmr: addr=%b din=%h required 0/00", bus.mmr_addr, bus.mmr_din);
    end
    clear_log();
    repeat (100) step();
    checks++;
    if (s_cyc.size() != 0) begin
      errors++;
      $display("FAIL mid_flush: got %0d strobes required 0", s_cyc.size());
    end
  endtask

  task automatic test_skipaddr();
    int low, exp_n, exp_span;
`ifdef JTOPLL_WRQ_SKIPADDR_EN
    exp_n = 3; exp_span = 103;
`else
    exp_n = 4; exp_span = 117;
`endif
    clear_log();
    push(1'b0, 8'h10);
    push(1'b1, 8'h01);
    push(1'b0, 8'h10);
    push(1'b1, 8'h02);
    wait_idle(600, low);
    checks++;
    if (s_cyc.size() != exp_n) begin
      errors++;
      $display("FAIL skip_count: got %0d strobes required %0d", s_cyc.size(), exp_n);
    end else begin
      checks++;
      if (s_cyc[exp_n-1] - s_cyc[0] != exp_span) begin
        errors++;
        $display("FAIL skip_span: last strobe %0d clks after first required %0d",
                 s_cyc[exp_n-1] - s_cyc[0], exp_span);
      end
      checks++;
      if (s_addr[exp_n-1] !== 1'b1 || s_din[exp_n-1] !== 8'h02 || s_din[1] !== 8'h01) begin
        errors++;
        $display("FAIL skip_value: last addr=%b din=%h second din=%h required 1/02/01",
                 s_addr[exp_n-1], s_din[exp_n-1], s_din[1]);
      end
    end
  endtask

  initial begin
    bus.cpu_wr = 1'b0; bus.cpu_addr = 1'b0; bus.cpu_din = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_cen_pacing();
    test_overflow();
    test_reset_mid();
    test_skipaddr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
